// File: rtl/tmds_video_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : tmds_video_tx_if
// Brief    : Pixel-stream handshake between a video source and tmds_video_tx.
// Revision : 1.0
// ============================================================================
interface tmds_video_tx_if;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_ready;

  modport master (output pix_valid, output pix_data, input  pix_ready);
  modport slave  (input  pix_valid, input  pix_data, output pix_ready);
endinterface
`default_nettype wire

// File: rtl/tmds_video_tx.sv
`default_nettype none
// ============================================================================
// Module   : tmds_video_tx
// Brief    : Raster timing generator and 3-channel DVI 8b/10b TMDS encoder.
//            Optional macro HDMI_GUARD_EN adds preamble + guard band per line.
// Revision : 1.0
// ============================================================================
module tmds_video_tx #(
  parameter int         H_ACTIVE = 1280,
  parameter int         H_FP     = 110,
  parameter int         H_SYNC   = 40,
  parameter int         H_BP     = 220,
  parameter int         V_ACTIVE = 720,
  parameter int         V_FP     = 5,
  parameter int         V_SYNC   = 5,
  parameter int         V_BP     = 20,
  parameter logic [1:0] SYNC_POL = 2'b11
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  tmds_video_tx_if.slave pix,
  output logic           frame_start,
  output logic           valid,
  output logic [29:0]    data,
  output logic           underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] c_H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] c_H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] c_HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] c_HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] c_V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] c_V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] c_VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] c_VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  function automatic logic [9:0] f_token(input logic [1:0] idx);
    case (idx)
      2'b00:   f_token = 10'b1101010100;
      2'b01:   f_token = 10'b0010101011;
      2'b10:   f_token = 10'b0101010100;
      default: f_token = 10'b1010101011;
    endcase
  endfunction

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          w_ready;
  logic          w_hs;
  logic          w_vs;
  logic          w_pre;
  logic          w_grd;

  // Idle position sits in the vertical front porch so restart always begins with blanking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= c_V_ACT;
    end else if (!en) begin
      r_h_cnt <= '0;
      r_v_cnt <= c_V_ACT;
    end else if (r_h_cnt == c_H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + VW'(1);
    end else begin
      r_h_cnt <= r_h_cnt + HW'(1);
    end
  end

  assign w_ready       = en && (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
  assign pix.pix_ready = w_ready;
  assign frame_start   = w_ready && (r_h_cnt == '0) && (r_v_cnt == '0);
  assign w_hs          = en && (r_h_cnt >= c_HS_BEG) && (r_h_cnt < c_HS_END);
  assign w_vs          = en && (r_v_cnt >= c_VS_BEG) && (r_v_cnt < c_VS_END);

`ifdef HDMI_GUARD_EN
  localparam logic [HW-1:0] c_PRE_BEG  = HW'(H_TOTAL - 10);
  localparam logic [HW-1:0] c_GRD_BEG  = HW'(H_TOTAL - 2);
  localparam logic [VW-1:0] c_V_ACT_M1 = VW'(V_ACTIVE - 1);
  logic w_next_active;
  assign w_next_active = (r_v_cnt == c_V_LAST) || (r_v_cnt < c_V_ACT_M1);
  assign w_pre = en && w_next_active && (r_h_cnt >= c_PRE_BEG) && (r_h_cnt < c_GRD_BEG);
  assign w_grd = en && w_next_active && (r_h_cnt >= c_GRD_BEG);
`else
  assign w_pre = 1'b0;
  assign w_grd = 1'b0;
`endif

  logic        r_s1_de;
  logic [23:0] r_s1_pix;
  logic        r_s1_hs;
  logic        r_s1_vs;
  logic        r_s1_pre;
  logic        r_s1_grd;
  logic        r_s1_en;
  logic        r_valid;
  logic        r_underflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_de     <= 1'b0;
      r_s1_pix    <= '0;
      r_s1_hs     <= ~SYNC_POL[0];
      r_s1_vs     <= ~SYNC_POL[1];
      r_s1_pre    <= 1'b0;
      r_s1_grd    <= 1'b0;
      r_s1_en     <= 1'b0;
      r_valid     <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_s1_de     <= w_ready;
      r_s1_pix    <= pix.pix_valid ? pix.pix_data : 24'h000000;
      r_s1_hs     <= w_hs ^ ~SYNC_POL[0];
      r_s1_vs     <= w_vs ^ ~SYNC_POL[1];
      r_s1_pre    <= w_pre;
      r_s1_grd    <= w_grd;
      r_s1_en     <= en;
      r_valid     <= r_s1_en;
      r_underflow <= r_underflow | (w_ready & ~pix.pix_valid);
    end
  end

  assign valid     = r_valid;
  assign underflow = r_underflow;

  for (genvar i = 0; i < 3; i++) begin : g_ch
    localparam logic [9:0] c_RST_SYM   = (i == 0) ? f_token(~SYNC_POL) : f_token(2'b00);
    localparam logic [9:0] c_GUARD_SYM = (i == 1) ? 10'b0100110011 : 10'b1011001100;

    logic [7:0]        w_d;
    logic [3:0]        w_n1d;
    logic [3:0]        w_n1q;
    logic              w_xnor;
    logic [8:0]        w_qm;
    logic signed [4:0] w_diff;
    logic [9:0]        w_enc;
    logic signed [4:0] w_enc_cnt;
    logic [1:0]        w_ctl;
    logic [9:0]        r_sym;
    logic signed [4:0] r_cnt;

    assign w_d = r_s1_pix[8*i +: 8];

    always_comb begin
      w_ctl = 2'b00;
      if (i == 0) begin
        w_ctl = {r_s1_vs, r_s1_hs};
      end else if (i == 1) begin
        w_ctl = {1'b0, r_s1_pre};
      end
    end

    always_comb begin
      w_n1d = '0;
      for (int b = 0; b < 8; b++) begin
        w_n1d = w_n1d + {3'b000, w_d[b]};
      end
      w_xnor = (w_n1d > 4'd4) || ((w_n1d == 4'd4) && !w_d[0]);
      w_qm    = '0;
      w_qm[0] = w_d[0];
      for (int b = 1; b < 8; b++) begin
        w_qm[b] = w_xnor ? ~(w_qm[b-1] ^ w_d[b]) : (w_qm[b-1] ^ w_d[b]);
      end
      w_qm[8] = ~w_xnor;
      w_n1q = '0;
      for (int b = 0; b < 8; b++) begin
        w_n1q = w_n1q + {3'b000, w_qm[b]};
      end
      // Ones minus zeros of q_m[7:0]; modular 5-bit math keeps 2*8-8 = 8 correct.
      w_diff = $signed({w_n1q, 1'b0}) - 5'sd8;
      if ((r_cnt == 5'sd0) || (w_n1q == 4'd4)) begin
        w_enc     = {~w_qm[8], w_qm[8], w_qm[8] ? w_qm[7:0] : ~w_qm[7:0]};
        w_enc_cnt = w_qm[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
      end else if ((!r_cnt[4] && (w_n1q > 4'd4)) || (r_cnt[4] && (w_n1q < 4'd4))) begin
        w_enc     = {1'b1, w_qm[8], ~w_qm[7:0]};
        w_enc_cnt = r_cnt + (w_qm[8] ? 5'sd2 : 5'sd0) - w_diff;
      end else begin
        w_enc     = {1'b0, w_qm[8], w_qm[7:0]};
        w_enc_cnt = r_cnt - (w_qm[8] ? 5'sd0 : 5'sd2) + w_diff;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sym <= c_RST_SYM;
        r_cnt <= '0;
      end else if (r_s1_grd) begin
        r_sym <= c_GUARD_SYM;
        r_cnt <= '0;
      end else if (r_s1_de) begin
        r_sym <= w_enc;
        r_cnt <= w_enc_cnt;
      end else begin
        r_sym <= f_token(w_ctl);
        r_cnt <= '0;
      end
    end

    assign data[10*i +: 10] = r_sym;
  end

endmodule
`default_nettype wire

// File: tb/tb_tmds_video_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmds_video_tx
// Brief    : Small-raster bench with a spec-level timing/encoding reference model.
// Revision : 1.0
// ============================================================================
module tb_tmds_video_tx;

  localparam int HA = 8, HF = 2, HS = 2, HB = 12;
  localparam int VA = 4, VF = 1, VS = 1, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam logic [1:0] SYNC_POL = 2'b11;
  localparam logic [9:0] GB_A = 10'b1011001100;
  localparam logic [9:0] GB_B = 10'b0100110011;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        frame_start;
  logic        valid;
  logic [29:0] data;
  logic        underflow;

  tmds_video_tx_if vif ();

  tmds_video_tx #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(SYNC_POL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pix        (vif),
    .frame_start(frame_start),
    .valid      (valid),
    .data       (data),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          pos;
  int          rd [3];
  logic [29:0] pipe_d [2];
  logic        pipe_v [2];
  logic        exp_uf;
  bit          zero_mode;
  logic        obs_ready;
  logic        obs_fs;
  logic [29:0] obs_data;

  task automatic chk(input string tag, input logic [29:0] obs, input logic [29:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] tok(input logic [1:0] idx);
    case (idx)
      2'b00:   tok = 10'b1101010100;
      2'b01:   tok = 10'b0010101011;
      2'b10:   tok = 10'b0101010100;
      default: tok = 10'b1010101011;
    endcase
  endfunction

  // q_m bit b is the parity of d[b:0], inverted on odd bits in XNOR mode.
  function automatic logic [9:0] ref_encode(input int ch, input logic [7:0] d);
    int         ones, q1, bal;
    bit         use_xnor;
    logic [8:0] qm;
    logic [7:0] mask;
    ones     = $countones(d);
    use_xnor = (ones > 4) || (ones == 4 && !d[0]);
    for (int b = 0; b < 8; b++) begin
      mask  = 8'((1 << (b + 1)) - 1);
      qm[b] = (^(d & mask)) ^ (use_xnor && (b % 2 == 1));
    end
    qm[8] = !use_xnor;
    q1  = $countones(qm[7:0]);
    bal = q1 - (8 - q1);
    if (rd[ch] == 0 || bal == 0) begin
      ref_encode = {!qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      rd[ch] += qm[8] ? bal : -bal;
    end else if ((rd[ch] > 0 && bal > 0) || (rd[ch] < 0 && bal < 0)) begin
      ref_encode = {1'b1, qm[8], ~qm[7:0]};
      rd[ch] += 2 * int'(qm[8]) - bal;
    end else begin
      ref_encode = {1'b0, qm[8], qm[7:0]};
      rd[ch] += bal - 2 * int'(!qm[8]);
    end
  endfunction

  task automatic model_reset();
    pos = VA * HT;
    for (int c = 0; c < 3; c++) rd[c] = 0;
    pipe_d[0] = {tok(2'b00), tok(2'b00), tok(~SYNC_POL)};
    pipe_d[1] = pipe_d[0];
    pipe_v[0] = 1'b0;
    pipe_v[1] = 1'b0;
    exp_uf    = 1'b0;
  endtask

  task automatic eval_cycle(input bit e, input bit pv);
    int          h, v;
    bit          rdy, fs, hs, vs, pre, grd;
    logic [1:0]  lvl;
    logic [23:0] px;
    logic [29:0] sym;
    en            = e;
    vif.pix_valid = pv;
    vif.pix_data  = zero_mode ? 24'h000000 : 24'($urandom);
    #1;
    h   = pos % HT;
    v   = pos / HT;
    rdy = e && (h < HA) && (v < VA);
    fs  = rdy && (h == 0) && (v == 0);
    obs_ready = vif.pix_ready;
    obs_fs    = frame_start;
    obs_data  = data;
    chk("pix_ready", 30'(vif.pix_ready), 30'(rdy));
    chk("frame_start", 30'(frame_start), 30'(fs));
    chk("valid", 30'(valid), 30'(pipe_v[1]));
    chk("data", data, pipe_d[1]);
    chk("underflow", 30'(underflow), 30'(exp_uf));
    if (rdy) begin
      px  = pv ? vif.pix_data : 24'h000000;
      sym = {ref_encode(2, px[23:16]), ref_encode(1, px[15:8]), ref_encode(0, px[7:0])};
      if (!pv) exp_uf = 1'b1;
    end else begin
      for (int c = 0; c < 3; c++) rd[c] = 0;
      hs  = e && (h >= HA + HF) && (h < HA + HF + HS);
      vs  = e && (v >= VA + VF) && (v < VA + VF + VS);
      pre = 1'b0;
      grd = 1'b0;
`ifdef HDMI_GUARD_EN
      if (e && (((v + 1) % VT) < VA)) begin
        pre = (h >= HT - 10) && (h <= HT - 3);
        grd = (h >= HT - 2);
      end
`endif
      lvl = {vs ^ !SYNC_POL[1], hs ^ !SYNC_POL[0]};
      if (grd) sym = {GB_A, GB_B, GB_A};
      else     sym = {tok(2'b00), tok(pre ? 2'b01 : 2'b00), tok(lvl)};
    end
    pipe_d[1] = pipe_d[0];
    pipe_d[0] = sym;
    pipe_v[1] = pipe_v[0];
    pipe_v[0] = e;
    pos = e ? (pos + 1) % FRAME : VA * HT;
  endtask

  task automatic run_cycle(input bit e, input bit pv);
    @(negedge clk);
    eval_cycle(e, pv);
  endtask

  task automatic run_to(input int target);
    int n;
    n = 0;
    while (pos != target && n <= FRAME) begin
      run_cycle(1'b1, 1'b1);
      n++;
    end
  endtask

  // Cycles from the first enabled cycle (at idle) to the first frame_start.
  task automatic measure_fs(output int lat);
    int n;
    n = 0;
    do begin
      run_cycle(1'b1, 1'b1);
      n++;
    end while (!obs_fs && n <= 2 * FRAME);
    lat = n - 1;
  endtask

  initial begin
    int lat, n_ready, fs_at, n_vs, n_hs, n_grd, n_pre;
    rst_n         = 1'b0;
    en            = 1'b0;
    vif.pix_valid = 1'b0;
    vif.pix_data  = '0;
    zero_mode     = 1'b1;
    model_reset();

    repeat (3) @(negedge clk);
    #1;
    chk("rst_data", data, 30'h354D5354);
    chk("rst_valid", 30'(valid), 30'd0);
    chk("rst_pix_ready", 30'(vif.pix_ready), 30'd0);
    chk("rst_underflow", 30'(underflow), 30'd0);

    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    eval_cycle(1'b0, 1'b1);
    measure_fs(lat);
    chk("first_fs_latency", 30'(lat), 30'((VT - VA) * HT));

    // One full frame of zero pixels: raster statistics and token placement.
    n_ready = 0; fs_at = 0; n_vs = 0; n_hs = 0; n_grd = 0; n_pre = 0;
    for (int j = 1; j <= FRAME; j++) begin
      run_cycle(1'b1, 1'b1);
      if (obs_ready) n_ready++;
      if (obs_fs && fs_at == 0) fs_at = j;
      if (obs_data[9:0] == 10'b0101010100 || obs_data[9:0] == 10'b1010101011) n_vs++;
      if (obs_data[9:0] == 10'b0010101011 || obs_data[9:0] == 10'b1010101011) n_hs++;
      if (obs_data == {GB_A, GB_B, GB_A}) n_grd++;
      if (obs_data[19:10] == 10'b0010101011 && obs_data[29:20] == 10'b1101010100) n_pre++;
    end
    chk("ready_per_frame", 30'(n_ready), 30'(HA * VA));
    chk("fs_period", 30'(fs_at), 30'(FRAME));
    chk("vsync_tokens", 30'(n_vs), 30'(HT * VS));
    chk("hsync_tokens", 30'(n_hs), 30'(HS * VT));
`ifdef HDMI_GUARD_EN
    chk("guard_symbols", 30'(n_grd), 30'(2 * VA));
    chk("preamble_symbols", 30'(n_pre), 30'(8 * VA));
`else
    chk("guard_symbols", 30'(n_grd), 30'd0);
    chk("preamble_symbols", 30'(n_pre), 30'd0);
`endif

    // Random pixels for a full frame.
    zero_mode = 1'b0;
    for (int j = 0; j < FRAME; j++) run_cycle(1'b1, 1'b1);

    // Single missing pixel mid-line.
    run_to(1 * HT + 2);
    run_cycle(1'b1, 1'b0);
    repeat (5) run_cycle(1'b1, 1'b1);
    chk("underflow_sticky", 30'(underflow), 30'd1);

    // Random pixel gaps across another frame.
    for (int j = 0; j < FRAME; j++) run_cycle(1'b1, 1'($urandom_range(0, 3) != 0));

    // Asynchronous reset mid-line.
    run_to(2 * HT + 5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_data", data, 30'h354D5354);
    chk("midrst_valid", 30'(valid), 30'd0);
    chk("midrst_pix_ready", 30'(vif.pix_ready), 30'd0);
    chk("midrst_underflow", 30'(underflow), 30'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    eval_cycle(1'b0, 1'b1);
    measure_fs(lat);
    chk("rst_fs_latency", 30'(lat), 30'((VT - VA) * HT));

    // Drop enable at h=3 of active line 2, then restart.
    run_to(2 * HT + 3);
    run_cycle(1'b0, 1'b1);
    repeat (6) run_cycle(1'b0, 1'b1);
    chk("idle_valid", 30'(valid), 30'd0);
    chk("idle_data", data, 30'h354D5354);
    measure_fs(lat);
    chk("reen_fs_latency", 30'(lat), 30'((VT - VA) * HT));
    for (int j = 0; j < FRAME; j++) run_cycle(1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
